// File: rtl/sine_lookup_arbiter.sv
// sine_lookup_arbiter
// Lets NREQ requesters share one combinational sine_table.
// A round-robin arbiter grants one eligible request per cycle.
// The winner's ID is registered onto tab_id.
// On the following edge, the table output is captured into the winner's response slot.
// A slot holds its sample until the requester consumes it.

module sine_lookup_arbiter #(
    parameter int NREQ      = 4,
    parameter int ROM_DEPTH = 64,
    parameter int ROM_WIDTH = 8,
    parameter int ADDRW     = $clog2(4*ROM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*ADDRW-1:0]     req_id,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [NREQ*2*ROM_WIDTH-1:0] rsp_data,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [ADDRW-1:0]          tab_id,
    input  logic [2*ROM_WIDTH-1:0]    tab_data
);

    localparam int PTRW = $clog2(NREQ);
    localparam int SW   = 2*ROM_WIDTH;

    logic [PTRW-1:0]  rr_ptr;
    logic [PTRW-1:0]  owner;
    logic [PTRW-1:0]  winner;
    logic             s1_v;
    logic             found;
    logic [NREQ-1:0]  eligible;
    logic [ADDRW-1:0] ids [NREQ];

    // Per-requester view: unpacked IDs, eligibility, grant, and the response slot.
    // A requester is eligible only when it has nothing held and nothing in flight.
    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        logic          valid_q;
        logic [SW-1:0] data_q;

        assign ids[g]      = req_id[g*ADDRW +: ADDRW];
        assign eligible[g] = req_valid[g] & ~valid_q & ~(s1_v && (owner == PTRW'(g)));
        assign req_ready[g] = rst_n & found & (winner == PTRW'(g));
        assign rsp_valid[g] = valid_q;
        assign rsp_data[g*SW +: SW] = data_q;

        // Capture the table sample when this slot owns stage 1; clear the valid flag on consume.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (s1_v && (owner == PTRW'(g))) begin
                valid_q <= 1'b1;
                data_q  <= tab_data;
            end else if (valid_q && rsp_ready[g]) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Round-robin search starting just after the last winner, wrapping explicitly at NREQ-1.
    always_comb begin
        int              sum;
        logic [PTRW-1:0] idx;
        winner = '0;
        found  = 1'b0;
        sum    = 0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = PTRW'(sum);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Stage 1 registers the granted ID toward the shared table and remembers its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tab_id <= '0;
            owner  <= '0;
            s1_v   <= 1'b0;
            rr_ptr <= PTRW'(NREQ-1);
        end else if (found) begin
            tab_id <= ids[winner];
            owner  <= winner;
            s1_v   <= 1'b1;
            rr_ptr <= winner;
        end else begin
            s1_v   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sine_lookup_arbiter.sv
// tb_sine_lookup_arbiter
// Directed bench for sine_lookup_arbiter with NREQ=4, ROM_DEPTH=64, ROM_WIDTH=8.
// A behavioural full-circle sine table (8.8 format) drives tab_data from tab_id.

module tb_sine_lookup_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_id;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_ready;
    logic [7:0]  tab_id;
    logic [15:0] tab_data;

    logic [15:0] sine_rom [256];

    int checks = 0;
    int errors = 0;

    sine_lookup_arbiter #(
        .NREQ(4),
        .ROM_DEPTH(64),
        .ROM_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_id(req_id),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_ready(rsp_ready),
        .tab_id(tab_id),
        .tab_data(tab_data)
    );

    // Free-running clock with rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Shared sine table: combinational lookup from the registered ID.
    assign tab_data = sine_rom[tab_id];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] ready);
        req_valid = valid;
        rsp_ready = ready;
        #1;
    endtask

    task automatic setId(input int idx, input logic [7:0] id);
        req_id[idx*8 +: 8] = id;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic singleLookup(input logic [7:0] id, input logic [15:0] expected);
        setId(0, id);
        applyStimulus(4'b0001, 4'b1111);
        checkOutput("t1_grant", 64'(req_ready), 64'h1);
        tick();
        checkOutput("t1_inflight_no_grant", 64'(req_ready), 64'h0);
        checkOutput("t1_tab_id", 64'(tab_id), 64'(id));
        applyStimulus(4'b0000, 4'b1111);
        checkOutput("t1_latency_not_yet", 64'(rsp_valid), 64'h0);
        tick();
        checkOutput("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("t1_rsp_data", 64'(rsp_data[15:0]), 64'(expected));
        tick();
        checkOutput("t1_consumed", 64'(rsp_valid), 64'h0);
    endtask

    initial begin
        logic [3:0] fair_ready [8];
        int         fair_owner [8];
        logic [7:0] fair_id [4];

        fair_ready = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        fair_owner = '{1, 2, 3, 0, 1, 2, 3, 0};
        fair_id    = '{8'd10, 8'd20, 8'd30, 8'd40};

        for (int k = 0; k < 256; k++) begin
            real r;
            int  v;
            r = 256.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
            if (r >= 0.0) v = $rtoi(r + 0.5);
            else          v = -$rtoi(-r + 0.5);
            sine_rom[k] = 16'(v);
        end

        rst_n     = 1'b0;
        req_valid = '0;
        req_id    = '0;
        rsp_ready = '0;
        #12;
        $display("[TB] reset state");
        checkOutput("rst_req_ready", 64'(req_ready), 64'h0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        checkOutput("rst_rsp_data", rsp_data, 64'h0);
        checkOutput("rst_tab_id", 64'(tab_id), 64'h0);
        checkOutput("rst_s1_v", 64'(dut.s1_v), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        $display("[TB] single lookups");
        singleLookup(8'd64, 16'h0100);
        singleLookup(8'd192, 16'hFF00);
        singleLookup(8'd0, 16'h0000);

        $display("[TB] fairness");
        for (int i = 0; i < 4; i++) setId(i, fair_id[i]);
        applyStimulus(4'b1111, 4'b1111);
        for (int c = 0; c < 8; c++) begin
            checkOutput("t2_grant", 64'(req_ready), 64'(fair_ready[c]));
            tick();
            checkOutput("t2_tab_id", 64'(tab_id), 64'(fair_id[fair_owner[c]]));
        end
        applyStimulus(4'b0000, 4'b1111);
        tick();
        tick();
        tick();
        checkOutput("t2_drained", 64'(rsp_valid), 64'h0);
        checkOutput("t2_held_data", rsp_data,
                    {sine_rom[40], sine_rom[30], sine_rom[20], sine_rom[10]});

        $display("[TB] backpressure");
        setId(1, 8'd64);
        applyStimulus(4'b0010, 4'b1101);
        checkOutput("t3_grant1", 64'(req_ready), 64'h2);
        tick();
        checkOutput("t3_inflight", 64'(req_ready), 64'h0);
        tick();
        checkOutput("t3_held_valid", 64'(rsp_valid), 64'h2);
        checkOutput("t3_held_data", 64'(rsp_data[31:16]), 64'h0100);
        setId(1, 8'd192);
        setId(2, 8'd128);
        applyStimulus(4'b0110, 4'b1101);
        checkOutput("t3_other_granted", 64'(req_ready), 64'h4);
        tick();
        applyStimulus(4'b0010, 4'b1101);
        checkOutput("t3_no_regrant", 64'(req_ready), 64'h0);
        tick();
        tick();
        checkOutput("t3_still_held", 64'(rsp_valid), 64'h2);
        checkOutput("t3_stable_data", 64'(rsp_data[31:16]), 64'h0100);
        applyStimulus(4'b0010, 4'b1111);
        checkOutput("t3_pre_consume", 64'(req_ready), 64'h0);
        tick();
        checkOutput("t3_consumed", 64'(rsp_valid), 64'h0);
        checkOutput("t3_regrant", 64'(req_ready), 64'h2);
        tick();
        applyStimulus(4'b0000, 4'b1111);
        tick();
        checkOutput("t3_new_data", 64'(rsp_data[31:16]), 64'hFF00);
        tick();

        $display("[TB] wrap");
        setId(3, 8'd32);
        applyStimulus(4'b1000, 4'b1111);
        checkOutput("t4_grant3", 64'(req_ready), 64'h8);
        tick();
        applyStimulus(4'b0000, 4'b1111);
        tick();
        tick();
        setId(0, 8'd16);
        setId(3, 8'd48);
        applyStimulus(4'b1001, 4'b1111);
        checkOutput("t4_wrap_to0", 64'(req_ready), 64'h1);
        tick();
        checkOutput("t4_then3", 64'(req_ready), 64'h8);
        tick();
        applyStimulus(4'b0000, 4'b1111);
        tick();
        tick();
        checkOutput("t4_data3", 64'(rsp_data[63:48]), 64'(sine_rom[48]));
        checkOutput("t4_data0", 64'(rsp_data[15:0]), 64'(sine_rom[16]));

        $display("[TB] reset mid-flight");
        setId(1, 8'd64);
        setId(2, 8'd192);
        applyStimulus(4'b0110, 4'b0000);
        checkOutput("t5_grant1", 64'(req_ready), 64'h2);
        tick();
        checkOutput("t5_grant2", 64'(req_ready), 64'h4);
        tick();
        checkOutput("t5_pre_reset_valid", 64'(rsp_valid), 64'h2);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_req_ready", 64'(req_ready), 64'h0);
        checkOutput("t5_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        checkOutput("t5_rst_rsp_data", rsp_data, 64'h0);
        checkOutput("t5_rst_tab_id", 64'(tab_id), 64'h0);
        checkOutput("t5_rst_s1_v", 64'(dut.s1_v), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("t5_first_after_reset", 64'(req_ready), 64'h2);
        tick();
        applyStimulus(4'b0000, 4'b1111);
        tick();
        checkOutput("t5_only_slot1", 64'(rsp_valid), 64'h2);
        checkOutput("t5_data1", 64'(rsp_data[31:16]), 64'h0100);
        tick();

        $display("[TB] sweep");
        for (int id = 0; id < 256; id++) begin
            setId(2, 8'(id));
            applyStimulus(4'b0100, 4'b1111);
            tick();
            applyStimulus(4'b0000, 4'b1111);
            tick();
            checkOutput("t6_sweep", 64'(rsp_data[47:32]), 64'(sine_rom[id]));
            if (id > 128) begin
                checkOutput("t6_sign", 64'(rsp_data[47]), 64'h1);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
